// File: rtl/spike_count_window.sv
// Per-step spike counter for a time-multiplexed motoneuron pool, plus a
// sliding sum over the last WIN completed steps for firing-rate readout.
module spike_count_window #(
  parameter int CNT_W    = 16,
  parameter int WIN_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spike_in,
  input  logic        spike_valid,
  input  logic        tick,
  output logic [31:0] spike_cnt,
  output logic [31:0] window_sum,
  output logic        cnt_valid,
  output logic        window_full,
  output logic        overflow
);

  localparam int WIN   = 1 << WIN_LOG2;
  localparam int SUM_W = CNT_W + WIN_LOG2;
  localparam logic [CNT_W-1:0]  ACC_MAX  = '1;
  localparam logic [WIN_LOG2:0] FILL_MAX = {1'b1, {WIN_LOG2{1'b0}}};

  logic [CNT_W-1:0]    acc;
  logic [CNT_W-1:0]    acc_plus;
  logic [CNT_W-1:0]    ring [WIN];
  logic [WIN_LOG2-1:0] wr_ptr;
  logic [WIN_LOG2:0]   fill;
  logic [CNT_W-1:0]    spike_cnt_r;
  logic [SUM_W-1:0]    window_sum_r;
  logic                cnt_event;
  logic                at_max;

  // acc_plus is the saturating closing count when tick is high, so an event
  // in the tick cycle belongs to the step being closed.
  always_comb begin
    cnt_event = spike_valid & spike_in;
    at_max    = (acc == ACC_MAX);
    acc_plus  = acc;
    if (cnt_event && !at_max) acc_plus = acc + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      wr_ptr       <= '0;
      fill         <= '0;
      spike_cnt_r  <= '0;
      window_sum_r <= '0;
      cnt_valid    <= 1'b0;
      overflow     <= 1'b0;
      for (int i = 0; i < WIN; i++) ring[i] <= '0;
    end else begin
      cnt_valid <= tick;
      if (cnt_event && at_max) overflow <= 1'b1;
      if (tick) begin
        acc          <= '0;
        spike_cnt_r  <= acc_plus;
        ring[wr_ptr] <= acc_plus;
        // Evicted slot is zero until the window has filled once.
        window_sum_r <= window_sum_r - SUM_W'(ring[wr_ptr]) + SUM_W'(acc_plus);
        wr_ptr       <= wr_ptr + 1'b1;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end else begin
        acc <= acc_plus;
      end
    end
  end

  assign spike_cnt   = 32'(spike_cnt_r);
  assign window_sum  = 32'(window_sum_r);
  assign window_full = (fill == FILL_MAX);

endmodule

// File: tb/tb_spike_count_window.sv
// Randomized + directed bench for spike_count_window (CNT_W=4 so saturation
// is reachable), checked against a queue-based model of completed steps.
module tb_spike_count_window;

  localparam int CNT_W    = 4;
  localparam int WIN_LOG2 = 3;
  localparam int WIN      = 1 << WIN_LOG2;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spike_in = 1'b0;
  logic        spike_valid = 1'b0;
  logic        tick = 1'b0;
  logic [31:0] spike_cnt;
  logic [31:0] window_sum;
  logic        cnt_valid;
  logic        window_full;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int step_ev = 0;
  int hist[$];
  int ticks = 0;
  int exp_cnt = 0;
  bit exp_valid = 0;
  bit exp_ovf = 0;

  spike_count_window #(.CNT_W(CNT_W), .WIN_LOG2(WIN_LOG2)) dut (
    .clk(clk),
    .reset(reset),
    .spike_in(spike_in),
    .spike_valid(spike_valid),
    .tick(tick),
    .spike_cnt(spike_cnt),
    .window_sum(window_sum),
    .cnt_valid(cnt_valid),
    .window_full(window_full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_sum();
    int s = 0;
    foreach (hist[i]) s += hist[i];
    return s;
  endfunction

  task automatic check_all();
    chk("spike_cnt", spike_cnt, exp_cnt);
    chk("window_sum", window_sum, model_sum());
    chk("cnt_valid", {31'd0, cnt_valid}, {31'd0, exp_valid});
    chk("window_full", {31'd0, window_full}, (ticks >= WIN) ? 32'd1 : 32'd0);
    chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  task automatic model_clear();
    step_ev = 0;
    hist.delete();
    ticks = 0;
    exp_cnt = 0;
    exp_valid = 0;
    exp_ovf = 0;
  endtask

  // Called at posedge+1; drives inputs for one cycle, then checks the result.
  task automatic cyc(input logic v, input logic s, input logic t);
    spike_valid = v;
    spike_in = s;
    tick = t;
    @(posedge clk);
    #1;
    if (v && s) begin
      if (step_ev >= MAXC) exp_ovf = 1;
      step_ev++;
    end
    exp_valid = t;
    if (t) begin
      exp_cnt = (step_ev > MAXC) ? MAXC : step_ev;
      hist.push_back(exp_cnt);
      if (hist.size() > WIN) void'(hist.pop_front());
      ticks++;
      step_ev = 0;
    end
    check_all();
  endtask

  task automatic run_step(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  // Asynchronous assert away from the clock edge, verified before any edge.
  task automatic do_reset();
    spike_valid = 1'b0;
    spike_in = 1'b0;
    tick = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    check_all();
    reset = 1'b0;

    // 5 events then plain tick
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("first_cnt5", spike_cnt, 32'd5);
    cyc(1'b0, 1'b0, 1'b0);
    chk("valid_one_cycle", {31'd0, cnt_valid}, 32'd0);

    // event coincident with tick, then empty step, then back-to-back ticks
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("tick_event_cnt4", spike_cnt, 32'd4);
    cyc(1'b0, 1'b0, 1'b1);
    chk("empty_step_cnt0", spike_cnt, 32'd0);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);

    // counts 1..10 from a clean window
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      run_step(k);
      if (k == 8) begin
        chk("win_full_at8", {31'd0, window_full}, 32'd1);
        chk("win_sum_36", window_sum, 32'd36);
      end
    end
    chk("win_sum_52", window_sum, 32'd52);

    // spike_in ignored without spike_valid
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("unqualified_cnt0", spike_cnt, 32'd0);

    // saturation, sticky overflow
    do_reset();
    run_step(20);
    chk("sat_cnt15", spike_cnt, 32'd15);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    run_step(2);
    run_step(0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // reset mid-step
    do_reset();
    for (int k = 0; k < 3; k++) run_step(7);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
    do_reset();
    chk("rst_sum0", window_sum, 32'd0);
    run_step(2);
    chk("post_rst_cnt2", spike_cnt, 32'd2);
    chk("post_rst_sum2", window_sum, 32'd2);

    // randomized traffic with a sparse mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 11) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
